// File: rtl/ram_burst_ctrl.sv
// Purpose: burst initiator for a 256x64 sync-read single-port RAM; write stream -> RAM, RAM -> read stream.
// Latency: write beats hit the RAM in the accepting cycle; first read beat is valid 3 cycles after the command.
// Backpressure: wr_valid gaps stall writes; rd_ready low stops issue once 3 words are outstanding.
module ram_burst_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 9
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_write,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [LEN_W-1:0]  i_cmd_len,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  input  logic              i_rd_ready,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_mem_address,
  output logic              o_mem_write,
  output logic [DATA_W-1:0] o_mem_in,
  input  logic [DATA_W-1:0] i_mem_out
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_cur_addr;
  logic [LEN_W-1:0]    r_beats_left;  // beats still to hand over (write accepts / read pops)
  logic [LEN_W-1:0]    r_issue_left;  // RAM reads still to issue
  logic                r_inflight;    // a read was issued last cycle; mem_out is valid now
  logic                r_cmd_ready;
  logic                r_wr_ready;
  logic                r_done;

  logic [DATA_W-1:0]   r_buf [3];
  logic [1:0]          r_rd_ptr;
  logic [1:0]          r_wr_ptr;
  logic [1:0]          r_buf_count;

  logic                w_cmd_acc;
  logic                w_wr_acc;
  logic [2:0]          w_occ;
  logic                w_issue;
  logic                w_push;
  logic                w_pop;

  function automatic logic [1:0] f_next_ptr(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign w_cmd_acc = i_cmd_valid && r_cmd_ready;
  assign w_wr_acc  = i_wr_valid && r_wr_ready;
  // Inflight word counts against the buffer so a push can never find it full.
  assign w_occ     = {1'b0, r_buf_count} + {2'b00, r_inflight};
  assign w_issue   = (r_state == S_READ) && (r_issue_left != '0) && (w_occ < 3'd3);
  assign w_push    = r_inflight;
  assign w_pop     = o_rd_valid && i_rd_ready;

  assign o_cmd_ready   = r_cmd_ready;
  assign o_wr_ready    = r_wr_ready;
  assign o_done        = r_done;
  assign o_rd_valid    = (r_buf_count != 2'd0);
  assign o_rd_data     = r_buf[r_rd_ptr];
  assign o_mem_address = r_cur_addr;
  assign o_mem_write   = (r_state == S_WRITE) && i_wr_valid;
  assign o_mem_in      = i_wr_data;

  // Burst sequencing: state, address/beat counters and registered handshake outputs.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= S_IDLE;
      r_cur_addr   <= '0;
      r_beats_left <= '0;
      r_issue_left <= '0;
      r_inflight   <= 1'b0;
      r_cmd_ready  <= 1'b1;
      r_wr_ready   <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      case (r_state)
        S_IDLE: begin
          if (w_cmd_acc) begin
            r_cur_addr   <= i_cmd_addr;
            r_beats_left <= i_cmd_len;
            r_issue_left <= i_cmd_len;
            r_cmd_ready  <= 1'b0;
            if (i_cmd_len == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else if (i_cmd_write) begin
              r_state    <= S_WRITE;
              r_wr_ready <= 1'b1;
            end else begin
              r_state <= S_READ;
            end
          end
        end
        S_WRITE: begin
          if (w_wr_acc) begin
            r_cur_addr   <= r_cur_addr + ADDR_W'(1);
            r_beats_left <= r_beats_left - LEN_W'(1);
            if (r_beats_left == LEN_W'(1)) begin
              r_state    <= S_DONE;
              r_wr_ready <= 1'b0;
              r_done     <= 1'b1;
            end
          end
        end
        S_READ: begin
          if (w_issue) begin
            r_cur_addr   <= r_cur_addr + ADDR_W'(1);
            r_issue_left <= r_issue_left - LEN_W'(1);
          end
          if (w_pop) begin
            r_beats_left <= r_beats_left - LEN_W'(1);
            if (r_beats_left == LEN_W'(1)) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_done      <= 1'b0;
          r_cmd_ready <= 1'b1;
        end
      endcase
    end
  end

  // Three-entry read buffer: mem_out is captured the cycle after its issue, head feeds rd_data.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < 3; i++) r_buf[i] <= '0;
      r_rd_ptr    <= 2'd0;
      r_wr_ptr    <= 2'd0;
      r_buf_count <= 2'd0;
    end else begin
      if (w_push) begin
        r_buf[r_wr_ptr] <= i_mem_out;
        r_wr_ptr        <= f_next_ptr(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= f_next_ptr(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_buf_count <= r_buf_count + 2'd1;
        2'b01:   r_buf_count <= r_buf_count - 2'd1;
        default: r_buf_count <= r_buf_count;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Bench for ram_burst_ctrl: RAM model on the memory pins, reference memory plus
// scoreboard queues for expected write and read beats, table of bursts plus hand sequences.
module tb_ram_burst_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_addr;
  logic [8:0]  cmd_len;
  logic [63:0] wr_data;
  logic        wr_valid, wr_ready;
  logic [63:0] rd_data;
  logic        rd_valid, rd_ready;
  logic        done;
  logic [7:0]  mem_address;
  logic        mem_write;
  logic [63:0] mem_in, mem_out;

  logic [63:0] ram     [256];
  logic [63:0] ref_mem [256];

  typedef struct packed {logic [7:0] a; logic [63:0] d;} wexp_t;
  wexp_t       wq[$];
  logic [63:0] rq[$];

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [8:0]  len;
    logic [63:0] base;
    logic [15:0] wgap;
    int          rd_hold;
    int          exp_first_rd;
    int          exp_done;
  } vec_t;
  vec_t vt[9];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ram_burst_ctrl dut (
    .i_clock(clk), .i_reset_n(rst_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
    .i_cmd_addr(cmd_addr), .i_cmd_len(cmd_len),
    .i_wr_data(wr_data), .i_wr_valid(wr_valid), .o_wr_ready(wr_ready),
    .o_rd_data(rd_data), .o_rd_valid(rd_valid), .i_rd_ready(rd_ready),
    .o_done(done), .o_mem_address(mem_address), .o_mem_write(mem_write),
    .o_mem_in(mem_in), .i_mem_out(mem_out)
  );

  // Synchronous-read single-port RAM
  always @(posedge clk) begin
    if (mem_write) ram[mem_address] <= mem_in;
    mem_out <= ram[mem_address];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic chk_reset_values();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_mem_in", mem_in, wr_data);
  endtask

  task automatic run_burst(input vec_t v);
    int          c;
    int          sent;
    int          got;
    int          first_rd;
    bit          seen_done;
    logic [7:0]  a;
    wexp_t       we;
    logic [63:0] rexp;
    for (int i = 0; i < int'(v.len); i++) begin
      a = v.addr + 8'(i);
      if (v.wr) begin
        wq.push_back({a, v.base + 64'(i)});
        ref_mem[a] = v.base + 64'(i);
      end else begin
        rq.push_back(ref_mem[a]);
      end
    end
    @(negedge clk);
    #1 chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_len = v.len;
    wr_valid = 1'b0; rd_ready = (v.rd_hold == 0);
    @(posedge clk);
    sent = 0; got = 0; first_rd = -1; seen_done = 1'b0;
    for (c = 1; c <= v.exp_done + 20 && !seen_done; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      wr_valid  = v.wr && (sent < int'(v.len)) && !((c < 16) ? v.wgap[c] : 1'b0);
      wr_data   = v.base + 64'(sent);
      rd_ready  = (c >= v.rd_hold);
      #1;
      chk("wr_ready", wr_ready, v.wr && (sent < int'(v.len)));
      chk("mem_write", mem_write, wr_valid);
      if (wr_valid && wr_ready) begin
        if (wq.size() == 0) chk("wq_underflow", 1, 0);
        else begin
          we = wq.pop_front();
          chk("wr_addr", mem_address, we.a);
          chk("wr_data", mem_in, we.d);
        end
        sent++;
      end
      if (rd_valid && first_rd < 0) first_rd = c;
      if (rd_valid && rd_ready) begin
        if (rq.size() == 0) chk("rq_underflow", 1, 0);
        else begin
          rexp = rq.pop_front();
          chk("rd_data", rd_data, rexp);
        end
        got++;
      end
      if (v.rd_hold > 8 && c == 8) begin
        chk("bp_issue_stop", mem_address, v.addr + 8'd3);
        chk("bp_rd_valid", rd_valid, 1);
      end
      if (done) begin
        seen_done = 1'b1;
        chk("done_cycle", c, v.exp_done);
        chk("cmd_ready_in_done", cmd_ready, 0);
      end
    end
    wr_valid = 1'b0;
    chk("done_seen", seen_done, 1);
    if (!v.wr && v.len != 0) chk("first_rd_cycle", first_rd, v.exp_first_rd);
    chk("beats", v.wr ? sent : got, v.len);
    chk("sb_empty", wq.size() + rq.size(), 0);
    if (v.wr)
      for (int i = 0; i < int'(v.len); i++) begin
        a = v.addr + 8'(i);
        chk("ram_contents", ram[a], ref_mem[a]);
      end
    @(negedge clk);
    #1;
    chk("cmd_ready_after_done", cmd_ready, 1);
    chk("done_low_after", done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) begin ram[i] = '0; ref_mem[i] = '0; end
    //          wr    addr   len     base      wgap      hold first done
    vt[0] = '{1'b1, 8'h10, 9'd4,   64'hA0,   16'h0018, 0, 0, 7};    // write with 2-cycle gap
    vt[1] = '{1'b0, 8'h10, 9'd4,   64'h0,    16'h0,    0, 3, 7};    // full-rate read
    vt[2] = '{1'b0, 8'h10, 9'd4,   64'h0,    16'h0,    9, 3, 13};   // backpressure
    vt[3] = '{1'b1, 8'hFE, 9'd4,   64'h1,    16'h0,    0, 0, 5};    // write across wrap
    vt[4] = '{1'b0, 8'hFE, 9'd4,   64'h0,    16'h0,    0, 3, 7};    // read across wrap
    vt[5] = '{1'b1, 8'h20, 9'd0,   64'h55,   16'h0,    0, 0, 1};    // zero-length write
    vt[6] = '{1'b0, 8'h30, 9'd0,   64'h0,    16'h0,    0, 0, 1};    // zero-length read
    vt[7] = '{1'b1, 8'h80, 9'd256, 64'h1000, 16'h0,    0, 0, 257};  // maximum length write
    vt[8] = '{1'b0, 8'h80, 9'd256, 64'h0,    16'h0,    0, 3, 259};  // maximum length read

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_data = 64'hDEAD_BEEF_0123_4567; wr_valid = 1'b0; rd_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk_reset_values();
    @(negedge clk) rst_n = 1'b1;

    for (int k = 0; k < 9; k++) run_burst(vt[k]);

    // Reset asserted in cycle 2 of a read burst
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h10; cmd_len = 9'd4; rd_ready = 1'b0;
    @(posedge clk);
    @(negedge clk) cmd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    wr_data = 64'h0F0F_0000_1234_5678;
    #1 chk_reset_values();
    @(negedge clk);
    #1 chk_reset_values();
    rst_n = 1'b1;
    #1 chk("post_rst_cmd_ready", cmd_ready, 1);
    chk("post_rst_ram_kept", ram[8'h10], ref_mem[8'h10]);
    run_burst(vt[1]);

    // Zero-length command, then a second command held valid through DONE
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h40; cmd_len = 9'd0; rd_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_write = 1'b0; cmd_addr = 8'h10; cmd_len = 9'd1;
    rq.push_back(ref_mem[8'h10]);
    #1;
    chk("held_done_c1", done, 1);
    chk("held_not_ready_c1", cmd_ready, 0);
    chk("zero_len_no_write", mem_write, 0);
    @(negedge clk);
    #1 chk("held_ready_c2", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    chk("held_accepted_c3", cmd_ready, 0);
    chk("held_latched_addr", mem_address, 8'h10);
    @(negedge clk);
    #1 chk("held_rd_valid_c4", rd_valid, 0);
    @(negedge clk);
    #1;
    chk("held_rd_valid_c5", rd_valid, 1);
    if (rq.size() != 0) begin
      rexp_pop();
    end else chk("held_rq_empty", 1, 0);
    @(negedge clk);
    #1 chk("held_done_c6", done, 1);
    chk("zero_len_ram_untouched", ram[8'h40], ref_mem[8'h40]);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  task automatic rexp_pop();
    logic [63:0] e;
    e = rq.pop_front();
    chk("held_rd_data", rd_data, e);
  endtask

endmodule
